layer_sequencer: RTL

Time-multiplexes one `neuron` MAC datapath across all `OUT_SIZE` neurons of a fully connected layer. For each neuron it selects the weight/bias row, pulses `neuron_go`, and captures `output_neuron` on `neuron_done`. It then rescales and saturates the result and writes it to the layer result buffer. It also tracks the argmax of the raw sums, which the classifier uses on the final layer. It sits between the top-level network FSM and the shared `neuron` instance plus its weight/bias ROM.

---
 rtl/nn_pkg.sv | 36 +++
 rtl/requant_sat.sv | 29 ++
 rtl/layer_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the layer blocks: sequencer state encoding and
// the arithmetic-shift-then-saturate function used by every requantizer.
package nn_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_ISSUE = 3'd1,
    SEQ_WAIT  = 3'd2,
    SEQ_WRITE = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_e;

  // Working width of sat_shift; callers sign-extend into it and truncate the result.
  localparam int unsigned SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] value,
    input int unsigned             shift,
    input int unsigned             width_res
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    s  = value >>> shift;
    hi = $signed((SAT_W'(1) << (width_res - 1)) - SAT_W'(1));
    lo = ~hi;
    if (s > hi) begin
      return hi;
    end
    if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational rescale unit: optional ReLU, arithmetic shift, signed saturation.
// LAYER_SEQ_RELU_EN clamps negative inputs to zero before shifting.
module requant_sat
  import nn_pkg::*;
#(
  parameter int unsigned WIDTH_IN  = 32,
  parameter int unsigned WIDTH_RES = 8,
  parameter int unsigned SHIFT     = 8
) (
  input  logic signed [WIDTH_IN-1:0]  value,
  output logic signed [WIDTH_RES-1:0] result_c
);

  logic signed [SAT_W-1:0] value_ext;
  logic signed [SAT_W-1:0] sat;

  always_comb begin
    value_ext = SAT_W'(value);
`ifdef LAYER_SEQ_RELU_EN
    if (value_ext[SAT_W-1]) begin
      value_ext = '0;
    end
`else
`endif
    sat      = sat_shift(value_ext, SHIFT, WIDTH_RES);
    result_c = WIDTH_RES'(sat);
  end

endmodule

// File: rtl/layer_sequencer.sv
// Runs one shared neuron datapath over every neuron of a fully connected layer,
// requantizes each sum into the result buffer and tracks the argmax of raw sums.
// Build option LAYER_SEQ_RELU_EN (in requant_sat) clamps stored results at zero.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned IN_SIZE   = 196,
  parameter int unsigned OUT_SIZE  = 32,
  parameter int unsigned WIDTH_OUT = 32,
  parameter int unsigned WIDTH_RES = 8,
  parameter int unsigned SHIFT     = 8,
  localparam int unsigned SEL_W    = $clog2(OUT_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        layer_go,
  output logic                        layer_busy,
  output logic                        layer_done,
  output logic [SEL_W-1:0]            neuron_sel,
  output logic                        neuron_go,
  input  logic                        neuron_done,
  input  logic signed [WIDTH_OUT-1:0] output_neuron,
  output logic                        res_we,
  output logic [SEL_W-1:0]            res_addr,
  output logic signed [WIDTH_RES-1:0] res_data,
  output logic [SEL_W-1:0]            max_idx
);

  if (IN_SIZE == 0 || OUT_SIZE < 2) begin : g_bad_params
    $error("layer_sequencer: IN_SIZE must be >= 1 and OUT_SIZE >= 2");
  end

  seq_state_e                 state_q;
  seq_state_e                 state_d;
  logic signed [WIDTH_OUT-1:0] acc_q;
  logic signed [WIDTH_OUT-1:0] max_val;
  logic [SEL_W-1:0]            max_cand;
  logic signed [WIDTH_RES-1:0] req_c;
  logic                        last_c;
  logic                        capture_c;
  logic                        max_upd_c;

  assign last_c    = (neuron_sel == SEL_W'(OUT_SIZE - 1));
  assign capture_c = (state_q == SEQ_WAIT) && neuron_done;
  // Strict greater-than keeps the lowest index on ties.
  assign max_upd_c = (state_q == SEQ_WRITE) && ((neuron_sel == '0) || (acc_q > max_val));

  // Requantize straight from the captured sum so res_data is ready during WRITE.
  requant_sat #(
    .WIDTH_IN (WIDTH_OUT),
    .WIDTH_RES(WIDTH_RES),
    .SHIFT    (SHIFT)
  ) u_requant (
    .value   (output_neuron),
    .result_c(req_c)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE:  if (layer_go) state_d = SEQ_ISSUE;
      SEQ_ISSUE: state_d = SEQ_WAIT;
      SEQ_WAIT:  if (neuron_done) state_d = SEQ_WRITE;
      SEQ_WRITE: state_d = last_c ? SEQ_DONE : SEQ_ISSUE;
      SEQ_DONE:  state_d = SEQ_IDLE;
      default:   state_d = SEQ_IDLE;
    endcase
  end

  // State, registered outputs, capture and argmax tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SEQ_IDLE;
      layer_busy <= 1'b0;
      layer_done <= 1'b0;
      neuron_go  <= 1'b0;
      res_we     <= 1'b0;
      neuron_sel <= '0;
      res_addr   <= '0;
      res_data   <= '0;
      acc_q      <= '0;
      max_val    <= '0;
      max_cand   <= '0;
      max_idx    <= '0;
    end else begin
      state_q    <= state_d;
      layer_busy <= (state_d != SEQ_IDLE);
      layer_done <= (state_d == SEQ_DONE);
      neuron_go  <= (state_d == SEQ_ISSUE);
      res_we     <= (state_d == SEQ_WRITE);
      if (state_q == SEQ_IDLE && state_d == SEQ_ISSUE) begin
        neuron_sel <= '0;
      end else if (state_q == SEQ_WRITE && state_d == SEQ_ISSUE) begin
        neuron_sel <= neuron_sel + SEL_W'(1);
      end
      if (capture_c) begin
        acc_q    <= output_neuron;
        res_data <= req_c;
        res_addr <= neuron_sel;
      end
      if (max_upd_c) begin
        max_val  <= acc_q;
        max_cand <= neuron_sel;
      end
      if (state_q == SEQ_DONE) begin
        max_idx <= max_cand;
      end
    end
  end

endmodule
